// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Fetch state encoding is {inflight, skid_valid}.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HELD   = 2'b01,
    STREAM = 2'b10
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  localparam int unsigned DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry instruction+PC holding register.
// Flush beats load, load beats drain.
module fetch_skid_buffer
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                load,
  input  logic                drain,
  input  logic [31:0]         load_data,
  input  logic [PC_WIDTH-1:0] load_pc,
  output logic                valid,
  output logic [31:0]         data,
  output logic [PC_WIDTH-1:0] pc
);

  // capture the returning word while the pipe is held
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= NOP_INSTR;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      pc    <= load_pc;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, memory issue,
// skid-protected stall and redirect flush.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                  PC_WIDTH = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC =
    PC_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                imem_en,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         if_id_reg,
  output logic [PC_WIDTH-1:0] if_pc,
  output logic                if_valid
);

  logic                pc_q;
  logic [PC_WIDTH-1:0] pc_r;
  logic                inflight;
  logic [PC_WIDTH-1:0] inflight_pc;
  logic                issue;
  logic                skid_valid;
  logic [31:0]         skid_data;
  logic [PC_WIDTH-1:0] skid_pc;
  fetch_state_t        state;

  assign pc_q = 1'b0;
  assign issue = !stall && !redirect_valid;
  assign imem_en = issue;
  assign imem_addr = pc_r;
  assign state = fetch_state_t'({inflight, skid_valid});

  fetch_skid_buffer #(
    .PC_WIDTH(PC_WIDTH)
  ) u_skid (
    .clock    (clock),
    .reset    (reset),
    .flush    (redirect_valid),
    .load     (stall && !redirect_valid && inflight),
    .drain    (issue && skid_valid),
    .load_data(imem_rdata),
    .load_pc  (inflight_pc),
    .valid    (skid_valid),
    .data     (skid_data),
    .pc       (skid_pc)
  );

  // PC advance and in-flight tracking
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_r        <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      pc_r     <= redirect_pc;
      inflight <= 1'b0;
    end else if (stall) begin
      inflight <= 1'b0;
    end else begin
      pc_r        <= pc_r + PC_WIDTH'(1);
      inflight    <= 1'b1;
      inflight_pc <= pc_r;
    end
  end

  // decode-facing register: skid first, then memory
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      if_id_reg <= NOP_INSTR;
      if_pc     <= '0;
      if_valid  <= 1'b0;
    end else if (redirect_valid) begin
      if_id_reg <= NOP_INSTR;
      if_valid  <= 1'b0;
    end else if (!stall) begin
      case (state)
        HELD: begin
          if_id_reg <= skid_data;
          if_pc     <= skid_pc;
          if_valid  <= 1'b1;
        end
        STREAM: begin
          if_id_reg <= imem_rdata;
          if_pc     <= inflight_pc;
          if_valid  <= 1'b1;
        end
        default: begin
          if_id_reg <= NOP_INSTR;
          if_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: stream model plus
// directed literal checks, two PC widths.
module tb_instr_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [9:0]  redirect_pc = '0;
  logic        imem_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic [31:0] if_id_reg;
  logic [9:0]  if_pc;
  logic        if_valid;

  logic        reset2 = 1'b1;
  logic        stall2 = 1'b0;
  logic        redir2 = 1'b0;
  logic [3:0]  redir_pc2 = '0;
  logic        imem_en2;
  logic [3:0]  imem_addr2;
  logic [31:0] imem_rdata2 = '0;
  logic [31:0] if_id_reg2;
  logic [3:0]  if_pc2;
  logic        if_valid2;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  instr_fetch #(.PC_WIDTH(10), .RESET_PC(10'd0)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .if_id_reg(if_id_reg),
    .if_pc(if_pc), .if_valid(if_valid)
  );

  instr_fetch #(.PC_WIDTH(4), .RESET_PC(4'd0)) dut4 (
    .clock(clock), .reset(reset2), .stall(stall2),
    .redirect_valid(redir2),
    .redirect_pc(redir_pc2),
    .imem_en(imem_en2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .if_id_reg(if_id_reg2),
    .if_pc(if_pc2), .if_valid(if_valid2)
  );

  function automatic logic [31:0] word1(int a);
    return 32'h2000_0000 + 32'(a);
  endfunction

  function automatic logic [31:0] word2(int a);
    return 32'h3000_0000 + 32'(a);
  endfunction

  // synchronous 1-cycle-latency memories
  always @(posedge clock) begin
    if (imem_en) imem_rdata <= word1(int'(imem_addr));
    if (imem_en2) imem_rdata2 <= word2(int'(imem_addr2));
  end

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t",
               name, act, exp, $time);
    end
  endtask

  // stream model: ordered list of issued-but-undelivered PCs
  int   m_next = 0;
  bit   m_valid = 0;
  int   m_pc = 0;
  int   pend[$];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_next = 0;
      m_valid = 0;
      m_pc = 0;
      pend.delete();
    end else if (redirect_valid) begin
      pend.delete();
      m_valid = 0;
      m_next = int'(redirect_pc);
    end else if (!stall) begin
      if (pend.size() > 0) begin
        m_pc = pend.pop_front();
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
      pend.push_back(m_next);
      m_next = (m_next + 1) % 1024;
    end
  end

  // compare DUT against model every cycle
  always @(negedge clock) begin
    if (chk_en) begin
      check("m_en", 32'(imem_en),
            32'(!stall && !redirect_valid));
      check("m_addr", 32'(imem_addr), 32'(m_next));
      check("m_valid", 32'(if_valid), 32'(m_valid));
      check("m_instr", if_id_reg,
            m_valid ? word1(m_pc) : 32'h0);
      if (m_valid)
        check("m_pc", 32'(if_pc), 32'(m_pc));
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_valid", 32'(if_valid), 32'h0);
    check("rst_instr", if_id_reg, 32'h0);
    check("rst_pc", 32'(if_pc), 32'h0);
    check("rst_addr", 32'(imem_addr), 32'h0);
    check("rst_skid", 32'(dut.skid_valid), 32'h0);
    reset = 1'b0;
    tick();
    check("e1_addr", 32'(imem_addr), 32'h1);
    check("e1_valid", 32'(if_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("run_instr", if_id_reg, 32'h2000_0000 + 32'(i));
      check("run_pc", 32'(if_pc), 32'(i));
      check("run_valid", 32'(if_valid), 32'h1);
    end
    tick();
    tick();
    stall = 1'b1;
    #1;
    check("stall_en", 32'(imem_en), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_instr", if_id_reg, 32'h2000_0004);
      check("hold_pc", 32'(if_pc), 32'h4);
      check("hold_en", 32'(imem_en), 32'h0);
    end
    stall = 1'b0;
    for (int i = 5; i < 8; i++) begin
      tick();
      check("rel_instr", if_id_reg, 32'h2000_0000 + 32'(i));
      check("rel_pc", 32'(if_pc), 32'(i));
    end
    stall = 1'b1;
    tick();
    check("skid_full", 32'(dut.skid_valid), 32'h1);
    redirect_valid = 1'b1;
    redirect_pc = 10'h3F0;
    tick();
    check("rd_valid0", 32'(if_valid), 32'h0);
    check("rd_addr", 32'(imem_addr), 32'h3F0);
    check("rd_idle", 32'(dut.state), 32'(cpu_pkg::IDLE));
    check("rd_skid", 32'(dut.skid_valid), 32'h0);
    redirect_valid = 1'b0;
    stall = 1'b0;
    tick();
    check("rd_valid1", 32'(if_valid), 32'h0);
    tick();
    check("rd_instr", if_id_reg, 32'h2000_03F0);
    check("rd_pc", 32'(if_pc), 32'h3F0);
    check("rd_vld", 32'(if_valid), 32'h1);
    for (int i = 0; i < 16; i++) tick();
    check("w10_pc", 32'(if_pc), 32'h0);
    check("w10_instr", if_id_reg, 32'h2000_0000);
    stall = 1'b1;
    tick();
    check("held_skid", 32'(dut.skid_valid), 32'h1);
    #1;
    reset = 1'b1;
    #1;
    check("ar_valid", 32'(if_valid), 32'h0);
    check("ar_instr", if_id_reg, 32'h0);
    check("ar_skid", 32'(dut.skid_valid), 32'h0);
    check("ar_addr", 32'(imem_addr), 32'h0);
    #3;
    reset = 1'b0;
    stall = 1'b0;
    tick();
    check("ar_issue", 32'(imem_addr), 32'h1);
    tick();
    check("ar_instr0", if_id_reg, 32'h2000_0000);
    check("ar_pc0", 32'(if_pc), 32'h0);
    reset2 = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (k == 15)
        check("w4_addr15", 32'(imem_addr2), 32'hF);
      if (k == 16) begin
        check("w4_addr0", 32'(imem_addr2), 32'h0);
        check("w4_pc14", 32'(if_pc2), 32'hE);
      end
      if (k == 17)
        check("w4_pc15", 32'(if_pc2), 32'hF);
      if (k == 18) begin
        check("w4_pc0", 32'(if_pc2), 32'h0);
        check("w4_instr0", if_id_reg2, 32'h3000_0000);
      end
      if (k == 19) begin
        check("w4_pc1", 32'(if_pc2), 32'h1);
        check("w4_vld", 32'(if_valid2), 32'h1);
      end
    end
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
